// File: rtl/tick_pkg.sv
// Shared types and defaults for the multi-channel tick generator.
// Channel state encoding is shared by the top and every channel instance.
package tick_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } chan_state_t;

  localparam int PRE_DIV_DEF = 1000;
  localparam int CNT_W_DEF   = 14;

endpackage

// File: rtl/tick_chan.sv
// One tick channel: IDLE/RUN/DONE FSM, divisor counter and registered tick pulse.
// Optional toggle output when TICK_TOGGLE_EN is defined.
module tick_chan
  import tick_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             tick_pre_i,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic             mode_i,
  input  logic [CNT_W-1:0] div_i,
  output logic             tick_o,
  output logic             running_o,
  output logic             done_o
`ifdef TICK_TOGGLE_EN
  ,
  output logic             tog_o
`endif
);

  chan_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic             mode_q, mode_d;
  logic             tick_q, tick_d;

  // Stop beats start; either one in a terminal cycle swallows that tick.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    mode_d  = mode_q;
    tick_d  = 1'b0;
    if (stop_i) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (start_i) begin
      state_d = RUN;
      cnt_d   = '0;
      div_d   = div_i;
      mode_d  = mode_i;
    end else if ((state_q == RUN) && tick_pre_i) begin
      if (cnt_q == div_q) begin
        tick_d = 1'b1;
        cnt_d  = '0;
        if (!mode_q) begin
          state_d = DONE;
        end
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      div_q   <= '0;
      mode_q  <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      mode_q  <= mode_d;
      tick_q  <= tick_d;
    end
  end

  assign tick_o    = tick_q;
  assign running_o = (state_q == RUN);
  assign done_o    = (state_q == DONE);

`ifdef TICK_TOGGLE_EN
  logic tog_q, tog_d;

  // Flips together with the tick register; start leaves the phase alone.
  always_comb begin
    tog_d = tog_q;
    if (stop_i) begin
      tog_d = 1'b0;
    end else if (tick_d) begin
      tog_d = ~tog_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tog_q <= 1'b0;
    end else begin
      tog_q <= tog_d;
    end
  end

  assign tog_o = tog_q;
`endif

endmodule

// File: rtl/tick_gen_multi.sv
// Multi-channel tick generator: shared prescaler feeding NCH tick_chan instances.
// Define TICK_TOGGLE_EN to add the per-channel tog square-wave output.
module tick_gen_multi
  import tick_pkg::*;
#(
  parameter int PRE_DIV = PRE_DIV_DEF,
  parameter int PRE_W   = 14,
  parameter int NCH     = 4,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [NCH-1:0]       start,
  input  logic [NCH-1:0]       stop,
  input  logic [NCH-1:0]       mode,
  input  logic [NCH*CNT_W-1:0] div_val,
  output logic                 tick_pre,
  output logic [NCH-1:0]       tick,
  output logic [NCH-1:0]       running,
  output logic [NCH-1:0]       done
`ifdef TICK_TOGGLE_EN
  ,
  output logic [NCH-1:0]       tog
`endif
);

  localparam logic [PRE_W-1:0] PRE_TC = PRE_W'(PRE_DIV);

  logic [PRE_W-1:0] cnt_pre_q, cnt_pre_d;

  // rst_n is active-high despite its name.
  always_comb begin
    cnt_pre_d = cnt_pre_q;
    if (en) begin
      cnt_pre_d = (cnt_pre_q == PRE_TC) ? '0 : cnt_pre_q + PRE_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      cnt_pre_q <= '0;
    end else begin
      cnt_pre_q <= cnt_pre_d;
    end
  end

  assign tick_pre = en && (cnt_pre_q == PRE_TC);

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    tick_chan #(
      .CNT_W(CNT_W)
    ) u_chan (
      .clk_i      (clk),
      .rst_i      (rst_n),
      .tick_pre_i (tick_pre),
      .start_i    (start[i]),
      .stop_i     (stop[i]),
      .mode_i     (mode[i]),
      .div_i      (div_val[i*CNT_W +: CNT_W]),
      .tick_o     (tick[i]),
      .running_o  (running[i]),
      .done_o     (done[i])
`ifdef TICK_TOGGLE_EN
      ,
      .tog_o      (tog[i])
`endif
    );
  end

endmodule

// File: tb/tb_tick_gen_multi.sv
// Self-checking bench for tick_gen_multi (PRE_DIV=4, NCH=2, CNT_W=4).
// A cycle-level behavioural model is compared against the DUT on every falling edge.
module tb_tick_gen_multi;

  localparam int PRE_DIV = 4;
  localparam int PRE_W   = 3;
  localparam int NCH     = 2;
  localparam int CNT_W   = 4;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 en;
  logic [NCH-1:0]       start, stop, mode;
  logic [NCH*CNT_W-1:0] div_val;
  logic                 tick_pre;
  logic [NCH-1:0]       tick, running, done;
`ifdef TICK_TOGGLE_EN
  logic [NCH-1:0]       tog;
`endif

  tick_gen_multi #(
    .PRE_DIV(PRE_DIV), .PRE_W(PRE_W), .NCH(NCH), .CNT_W(CNT_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .start    (start),
    .stop     (stop),
    .mode     (mode),
    .div_val  (div_val),
    .tick_pre (tick_pre),
    .tick     (tick),
    .running  (running),
    .done     (done)
`ifdef TICK_TOGGLE_EN
    ,
    .tog      (tog)
`endif
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int rst_pulses = 0;
  int tick0_q[$];
  int tick1_n = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  initial forever begin
    @(posedge rst_n);
    rst_pulses++;
  end

  // Behavioural model: tick_pre fires on every (PRE_DIV+1)-th enabled cycle; a
  // channel ticks after every (div+1)-th tick_pre counted since its last start.
  int en_cycles;
  int m_st[NCH];
  int m_seen[NCH];
  int m_div[NCH];
  bit m_per[NCH];
  bit m_tick[NCH];
  bit m_tog[NCH];

  initial begin
    int last_rp;
    bit tp_exp;
    last_rp = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_n || (rst_pulses != last_rp)) begin
        last_rp   = rst_pulses;
        en_cycles = 0;
        for (int c = 0; c < NCH; c++) begin
          m_st[c] = 0; m_seen[c] = 0; m_div[c] = 0;
          m_per[c] = 0; m_tick[c] = 0; m_tog[c] = 0;
        end
      end
      tp_exp = en && ((en_cycles % (PRE_DIV + 1)) == PRE_DIV);
      chk("tick_pre", 32'(tick_pre), 32'(tp_exp));
      for (int c = 0; c < NCH; c++) begin
        chk($sformatf("tick[%0d]", c), 32'(tick[c]), 32'(m_tick[c]));
        chk($sformatf("running[%0d]", c), 32'(running[c]), 32'(m_st[c] == 1));
        chk($sformatf("done[%0d]", c), 32'(done[c]), 32'(m_st[c] == 2));
`ifdef TICK_TOGGLE_EN
        chk($sformatf("tog[%0d]", c), 32'(tog[c]), 32'(m_tog[c]));
`endif
      end
      if (tick[0] === 1'b1) tick0_q.push_back(cyc);
      if (tick[1] === 1'b1) tick1_n++;
      if (!rst_n) begin
        for (int c = 0; c < NCH; c++) begin
          m_tick[c] = 0;
          if (stop[c]) begin
            m_st[c]  = 0;
            m_tog[c] = 0;
          end else if (start[c]) begin
            m_st[c]   = 1;
            m_div[c]  = int'(div_val[c*CNT_W +: CNT_W]);
            m_per[c]  = mode[c];
            m_seen[c] = 0;
          end else if (m_st[c] == 1 && tp_exp) begin
            m_seen[c]++;
            if ((m_seen[c] % (m_div[c] + 1)) == 0) begin
              m_tick[c] = 1;
              m_tog[c]  = ~m_tog[c];
              if (!m_per[c]) m_st[c] = 2;
            end
          end
        end
        if (en) en_cycles++;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input int c, input bit md, input int dv);
    start[c] = 1'b1;
    mode[c]  = md;
    div_val[c*CNT_W +: CNT_W] = CNT_W'(dv);
    step(1);
    start[c] = 1'b0;
  endtask

  task automatic wait_tick0(input int target, input int limit, input string nm);
    int k;
    k = 0;
    while (tick0_q.size() < target && k < limit) begin
      step(1);
      k++;
    end
    chk(nm, 32'(tick0_q.size() >= target), 32'd1);
  endtask

  initial begin
    int a, b, t1;
    rst_n = 1'b1; en = 1'b0;
    start = '0; stop = '0; mode = '0; div_val = '0;
    step(3);
    chk("reset_tick", 32'(tick), 32'd0);
    chk("reset_running", 32'(running), 32'd0);
    rst_n = 1'b0; en = 1'b1;

    // 1: idle prescaler, two tick_pre per 10 clocks
    step(2);
    a = 0;
    for (int i = 0; i < 10; i++) begin
      a += int'(tick_pre);
      step(1);
    end
    chk("t1_tickpre_count", a, 32'd2);
    chk("t1_done", 32'(done), 32'd0);

    // 2: ch0 periodic, div=2 -> 15 clk period
    a = tick0_q.size();
    pulse_start(0, 1'b1, 2);
    wait_tick0(a + 3, 60, "t2_ticks_seen");
    if (tick0_q.size() >= a + 3) begin
      chk("t2_period_a", tick0_q[a+1] - tick0_q[a], 32'd15);
      chk("t2_period_b", tick0_q[a+2] - tick0_q[a+1], 32'd15);
    end
    chk("t2_running0", 32'(running[0]), 32'd1);

    // 3: ch1 one-shot, div=0 -> exactly one tick, then DONE
    b = tick1_n;
    pulse_start(1, 1'b0, 0);
    step(20);
    chk("t3_one_tick", tick1_n - b, 32'd1);
    chk("t3_done1", 32'(done[1]), 32'd1);
    chk("t3_running1", 32'(running[1]), 32'd0);

    // 4a: start+stop together on running ch0 -> IDLE, no ticks
    start[0] = 1'b1; stop[0] = 1'b1;
    step(1);
    start[0] = 1'b0; stop[0] = 1'b0;
    a = tick0_q.size();
    step(20);
    chk("t4_idle_running", 32'(running[0]), 32'd0);
    chk("t4_no_tick", tick0_q.size() - a, 32'd0);

    // 4b: restart exactly in a terminal cycle -> tick suppressed, RUN kept
    pulse_start(0, 1'b1, 0);
    a = 0;
    while (tick_pre !== 1'b1 && a < 10) begin
      step(1);
      a++;
    end
    chk("t4_found_tickpre", 32'(tick_pre), 32'd1);
    pulse_start(0, 1'b1, 0);
    chk("t4_suppressed", 32'(tick[0]), 32'd0);
    chk("t4_still_run", 32'(running[0]), 32'd1);

    // 5: en low for 7 clk shifts the next tick by exactly 7
    pulse_start(0, 1'b1, 2);
    a = tick0_q.size();
    wait_tick0(a + 1, 60, "t5_first_tick");
    t1 = (tick0_q.size() > a) ? tick0_q[a] : 0;
    step(4);
    en = 1'b0;
    step(7);
    en = 1'b1;
    wait_tick0(a + 2, 60, "t5_second_tick");
    if (tick0_q.size() >= a + 2) chk("t5_shifted_period", tick0_q[a+1] - t1, 32'd22);

    // 6: asynchronous reset pulse between edges mid-run
    step(3);
    #1 rst_n = 1'b1;
    #1;
    chk("t6_running_now", 32'(running), 32'd0);
    chk("t6_done_now", 32'(done), 32'd0);
    chk("t6_tickpre_now", 32'(tick_pre), 32'd0);
    #1 rst_n = 1'b0;
    a = tick0_q.size();
    step(20);
    chk("t6_no_tick_after", tick0_q.size() - a, 32'd0);

    // stop after a tick clears the channel (and tog when present)
    pulse_start(0, 1'b1, 0);
    a = tick0_q.size();
    wait_tick0(a + 1, 20, "t7_tick");
    stop[0] = 1'b1;
    step(1);
    stop[0] = 1'b0;
    chk("t7_stopped", 32'(running[0]), 32'd0);
`ifdef TICK_TOGGLE_EN
    chk("t7_tog_cleared", 32'(tog[0]), 32'd0);
`endif
    step(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
